// File: rtl/seq_dect_frame_ctrl_pkg.sv
// rtl/seq_dect_frame_ctrl_pkg.sv - shared widths and state encoding for the frame controller
package seq_dect_frame_ctrl_pkg;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_LEN_W  = 8;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/seq_dect_serializer.sv
// rtl/seq_dect_serializer.sv - MSB-first word shift register with bit counter
module seq_dect_serializer
    import seq_dect_frame_ctrl_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] load_data,
    output logic              msb,
    output logic              last
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] sr_q, sr_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;

    // Load wins over shift so a back-to-back word replaces the finishing one.
    always_comb begin
        sr_d      = sr_q;
        bit_idx_d = bit_idx_q;
        if (load) begin
            sr_d      = load_data;
            bit_idx_d = '0;
        end else if (shift) begin
            sr_d      = {sr_q[WORD_W-2:0], 1'b0};
            bit_idx_d = bit_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr_q      <= '0;
            bit_idx_q <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    assign msb  = sr_q[WORD_W-1];
    assign last = (bit_idx_q == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/seq_dect_frame_ctrl.sv
// rtl/seq_dect_frame_ctrl.sv - frames words onto a serial 10101 detector and counts its hits
module seq_dect_frame_ctrl
    import seq_dect_frame_ctrl_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              det_d,
    output logic              det_reset_n,
    input  logic              det_q,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              match_ovf
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   words_left_q, words_left_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic               match_ovf_q, match_ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               det_reset_n_q, det_reset_n_d;
    logic               ser_load, ser_shift, ser_msb, ser_last;
    logic               more_words;

    seq_dect_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (ser_load),
        .shift     (ser_shift),
        .load_data (in_data),
        .msb       (ser_msb),
        .last      (ser_last)
    );

    assign more_words = (words_left_q > LEN_W'(1));
    // Ready on the last bit of a non-final word lets the next word follow with no bubble.
    assign in_ready   = (state_q == WAIT) || (state_q == SHIFT && ser_last && more_words);

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        match_cnt_d  = match_cnt_q;
        match_ovf_d  = match_ovf_q;
        ser_load     = 1'b0;
        ser_shift    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    match_cnt_d = '0;
                    match_ovf_d = 1'b0;
                    if (frame_len != '0) begin
                        words_left_d = frame_len;
                        state_d      = CLR;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CLR: state_d = WAIT;
            WAIT: begin
                if (in_valid) begin
                    ser_load = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                ser_shift = 1'b1;
                if (det_q) begin
                    if (match_cnt_q != '1) match_cnt_d = match_cnt_q + 1'b1;
                    else                   match_ovf_d = 1'b1;
                end
                if (ser_last) begin
                    if (more_words) begin
                        words_left_d = words_left_q - 1'b1;
                        if (in_valid) ser_load = 1'b1;
                        else          state_d  = WAIT;
                    end else begin
                        words_left_d = '0;
                        state_d      = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
        det_reset_n_d = (state_d != CLR);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            words_left_q  <= '0;
            match_cnt_q   <= '0;
            match_ovf_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            det_reset_n_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            words_left_q  <= words_left_d;
            match_cnt_q   <= match_cnt_d;
            match_ovf_q   <= match_ovf_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            det_reset_n_q <= det_reset_n_d;
        end
    end

    assign det_d       = (state_q == SHIFT) && ser_msb;
    assign det_reset_n = det_reset_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign match_cnt   = match_cnt_q;
    assign match_ovf   = match_ovf_q;

endmodule

// File: tb/tb_seq_dect_frame_ctrl.sv
// tb/tb_seq_dect_frame_ctrl.sv - randomized frame bench with a bit-stream reference model
module tb_seq_dect_frame_ctrl;

    localparam int WORD_W = 8;
    localparam int LEN_W  = 8;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [LEN_W-1:0]  frame_len;
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic              det_d;
    logic              det_reset_n;
    logic              det_q;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  match_cnt;
    logic              match_ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [WORD_W-1:0] frm_words [16];
    int                frm_gaps  [16];

    always #5 clk = ~clk;

    seq_dect_frame_ctrl #(.WORD_W(WORD_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .frame_len   (frame_len),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .det_d       (det_d),
        .det_reset_n (det_reset_n),
        .det_q       (det_q),
        .busy        (busy),
        .done        (done),
        .match_cnt   (match_cnt),
        .match_ovf   (match_ovf)
    );

    // External Mealy 10101 detector: remembers the last four bits since its clear.
    logic [3:0] hist;
    always @(posedge clk) begin
        if (!det_reset_n) hist <= 4'b0;
        else              hist <= {hist[2:0], det_d};
    end
    assign det_q = det_reset_n && ({hist, det_d} == 5'b10101);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"},    in_ready,    0);
        check_eq({tag, "_det_d"},       det_d,       0);
        check_eq({tag, "_det_reset_n"}, det_reset_n, 0);
        check_eq({tag, "_busy"},        busy,        0);
        check_eq({tag, "_done"},        done,        0);
        check_eq({tag, "_match_cnt"},   match_cnt,   0);
        check_eq({tag, "_match_ovf"},   match_ovf,   0);
    endtask

    // Runs one frame from IDLE using frm_words/frm_gaps; gap i is how many ready
    // cycles the producer withholds before offering word i.
    task automatic run_frame(input int len, input string tag);
        bit trace[$];
        bit exp_t[$];
        int idx = 0, gap, cyc = 1, done_at = -1, clr_cycles = 0, mism = 0;
        int hits = 0, exp_lat, gap_sum = 0;
        bit saw_ready = 0;

        if (len > 0) begin
            exp_t.push_back(1'b0);
            repeat (frm_gaps[0] + 1) exp_t.push_back(1'b0);
            for (int i = 0; i < len; i++) begin
                if (i > 0) begin
                    repeat (frm_gaps[i]) exp_t.push_back(1'b0);
                    gap_sum += frm_gaps[i];
                end
                for (int b = WORD_W - 1; b >= 0; b--) exp_t.push_back(frm_words[i][b]);
            end
        end
        for (int k = 4; k < exp_t.size(); k++)
            if (exp_t[k-4] && !exp_t[k-3] && exp_t[k-2] && !exp_t[k-1] && exp_t[k]) hits++;
        exp_lat = (len == 0) ? 1 : 3 + frm_gaps[0] + WORD_W * len + gap_sum;

        start     = 1'b1;
        frame_len = LEN_W'(len);
        in_valid  = 1'b0;
        step();
        frame_len = LEN_W'($urandom);
        gap = frm_gaps[0];
        while (done_at < 0 && cyc < 2000) begin
            start    = 1'($urandom_range(0, 1));
            in_valid = (idx < len) && (gap == 0);
            in_data  = in_valid ? frm_words[idx] : WORD_W'($urandom);
            if (in_ready) saw_ready = 1'b1;
            if (!det_reset_n) clr_cycles++;
            if (done) begin
                done_at = cyc;
                start   = 1'b0;
                check_eq({tag, "_busy_in_done"},  busy,     1);
                check_eq({tag, "_ready_in_done"}, in_ready, 0);
            end else begin
                trace.push_back(det_d);
            end
            if (in_ready && in_valid) begin
                idx++;
                gap = (idx < len) ? frm_gaps[idx] : 0;
            end else if (in_ready && gap > 0) begin
                gap--;
            end
            step();
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (done_at < 0) begin
            check_eq({tag, "_timeout"}, 0, 1);
        end else begin
            check_eq({tag, "_done_latency"}, done_at, exp_lat);
            check_eq({tag, "_trace_len"}, trace.size(), exp_t.size());
            for (int k = 0; k < trace.size() && k < exp_t.size(); k++)
                if (trace[k] != exp_t[k]) mism++;
            check_eq({tag, "_det_d_bits"}, mism, 0);
            check_eq({tag, "_clr_cycles"}, clr_cycles, (len > 0) ? 1 : 0);
            if (len == 0) check_eq({tag, "_ready_never"}, saw_ready, 0);
            check_eq({tag, "_done_once"}, done, 0);
            check_eq({tag, "_idle"},      busy, 0);
            check_eq({tag, "_match_cnt"}, match_cnt, (hits > CNT_MAX) ? CNT_MAX : hits);
            check_eq({tag, "_match_ovf"}, match_ovf, (hits > CNT_MAX) ? 1 : 0);
        end
    endtask

    initial begin
        logic [WORD_W-1:0] picks [5];
        int len;
        picks[0] = 8'hA8; picks[1] = 8'h15; picks[2] = 8'h05; picks[3] = 8'h40; picks[4] = 8'h55;

        reset_n = 1'b0; start = 1'b0; frame_len = '0; in_valid = 1'b0; in_data = '0;
        for (int i = 0; i < 16; i++) begin frm_words[i] = '0; frm_gaps[i] = 0; end
        step();
        step();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        step();

        frm_words[0] = 8'hA8; frm_gaps[0] = 0;
        run_frame(1, "single");

        frm_words[0] = 8'h05; frm_words[1] = 8'h40; frm_gaps[1] = 0;
        run_frame(2, "cross");

        frm_words[0] = 8'h05;
        run_frame(1, "iso_a");
        frm_words[0] = 8'h40;
        run_frame(1, "iso_b");

        for (int i = 0; i < 4; i++) begin frm_words[i] = 8'hA8; frm_gaps[i] = 0; end
        run_frame(4, "sat");
        repeat (3) step();
        check_eq("sat_hold_cnt", match_cnt, CNT_MAX);
        check_eq("sat_hold_ovf", match_ovf, 1);
        run_frame(0, "zero_len");

        frm_words[0] = 8'hA8; frm_gaps[0] = 5;
        run_frame(1, "backpressure");
        frm_gaps[0] = 0;

        start = 1'b1; frame_len = LEN_W'(2);
        step();
        start = 1'b0; in_valid = 1'b1; in_data = 8'hA8;
        step();
        step();
        check_eq("first_bit_latency", det_d, 1);
        step();
        step();
        reset_n = 1'b0; in_valid = 1'b0;
        step();
        check_reset_outputs("mid_reset");
        reset_n = 1'b1;
        step();
        run_frame(1, "after_reset");

        for (int f = 0; f < 25; f++) begin
            len = $urandom_range(0, 5);
            for (int i = 0; i < len; i++) begin
                frm_words[i] = ($urandom_range(0, 2) == 0) ? WORD_W'($urandom) : picks[$urandom_range(0, 4)];
                frm_gaps[i]  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            end
            run_frame(len, $sformatf("rand%0d", f));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
